// File: rtl/aurora_20g_enc_gen.sv
// Test-pattern source for the 20G Aurora encoder-word checker: {pattern, seq} words with gaps,
// bursts and backpressure. Optional error injection under `AURORA_ENC_GEN_ERR_INJ_EN.
module aurora_20g_enc_gen #(
   parameter int DATA_WD = 64,
   parameter int GAP_WD  = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cfg_rst,
   input  logic               cfg_start,
   input  logic               cfg_stop,
   input  logic               cfg_mode,
   input  logic [31:0]        cfg_num,
   input  logic [GAP_WD-1:0]  cfg_gap,
`ifdef AURORA_ENC_GEN_ERR_INJ_EN
   input  logic               cfg_err_inj,
`endif
   input  logic               tx_rdy,
   output logic               enc_vld,
   output logic [DATA_WD-1:0] enc_data,
   output logic               busy,
   output logic               done,
   output logic [31:0]        tx_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

   // Fixed pattern sits above the 16-bit seq, truncated or zero-extended at the MSB end.
   localparam logic [DATA_WD+63:0] P_EXT = {{DATA_WD{1'b0}}, 48'hBBBB_CCCC_DDDD, 16'h0000};
   localparam logic [DATA_WD-1:0]  P_PAT = P_EXT[DATA_WD-1:0];

   state_t              r_state, w_nxt;
   logic [15:0]         r_seq;
   logic [31:0]         r_cnt, r_rem, w_rem_nxt;
   logic [GAP_WD-1:0]   r_gap, r_gap_cnt, w_gap_cnt_nxt;
   logic                r_mode, r_stop, w_stop_nxt, r_done, w_done, w_load;
   logic [DATA_WD-1:0]  r_data;
   logic                w_acc, w_hold;
   logic [15:0]         w_seq_nxt, w_mask;

   assign enc_vld   = (r_state == S_SEND);
   assign w_acc     = enc_vld & tx_rdy;
   assign w_hold    = enc_vld & ~tx_rdy;
   assign w_seq_nxt = w_acc ? r_seq + 16'd1 : r_seq;

`ifdef AURORA_ENC_GEN_ERR_INJ_EN
   logic r_inj, w_inj_now, w_new_word;
   assign w_inj_now  = r_inj | cfg_err_inj;
   assign w_new_word = ~w_hold & (w_nxt == S_SEND);
   assign w_mask     = w_inj_now ? 16'hFFFF : 16'h0000;

   // The corruption is baked into r_data when the word is loaded, so it holds through backpressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                      r_inj <= 1'b0;
      else if (cfg_rst)                r_inj <= 1'b0;
      else if (w_new_word & w_inj_now) r_inj <= 1'b0;
      else if (cfg_err_inj)            r_inj <= 1'b1;
   end
`else
   assign w_mask = 16'h0000;
`endif

   always_comb begin
      w_nxt         = r_state;
      w_done        = 1'b0;
      w_load        = 1'b0;
      w_stop_nxt    = r_stop;
      w_rem_nxt     = r_rem;
      w_gap_cnt_nxt = r_gap_cnt;
      case (r_state)
         S_IDLE: begin
            w_stop_nxt = 1'b0;
            if (cfg_start) begin
               if (cfg_mode || cfg_num != 32'd0) begin
                  w_nxt     = S_SEND;
                  w_load    = 1'b1;
                  w_rem_nxt = cfg_num;
               end else begin
                  w_done = 1'b1;
               end
            end
         end
         S_SEND: begin
            if (w_acc) begin
               if (r_rem != 32'd0) w_rem_nxt = r_rem - 32'd1;
               if ((!r_mode && r_rem == 32'd1) || r_stop || cfg_stop) begin
                  w_nxt      = S_IDLE;
                  w_done     = 1'b1;
                  w_stop_nxt = 1'b0;
               end else if (r_gap != '0) begin
                  w_nxt         = S_GAP;
                  w_gap_cnt_nxt = r_gap;
               end
            end else if (cfg_stop) begin
               w_stop_nxt = 1'b1;
            end
         end
         S_GAP: begin
            if (cfg_stop) begin
               w_nxt      = S_IDLE;
               w_done     = 1'b1;
               w_stop_nxt = 1'b0;
            end else if (r_gap_cnt <= GAP_WD'(1)) begin
               w_nxt = S_SEND;
            end else begin
               w_gap_cnt_nxt = r_gap_cnt - GAP_WD'(1);
            end
         end
         default: w_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;   r_seq  <= '0;  r_cnt  <= '0;  r_rem <= '0;
         r_gap   <= '0;       r_gap_cnt <= '0; r_mode <= 1'b0; r_stop <= 1'b0;
         r_done  <= 1'b0;     r_data <= '0;
      end else if (cfg_rst) begin
         r_state <= S_IDLE;   r_seq  <= '0;  r_cnt  <= '0;  r_rem <= '0;
         r_gap   <= '0;       r_gap_cnt <= '0; r_mode <= 1'b0; r_stop <= 1'b0;
         r_done  <= 1'b0;     r_data <= '0;
      end else begin
         r_state   <= w_nxt;
         r_seq     <= w_seq_nxt;
         r_rem     <= w_rem_nxt;
         r_gap_cnt <= w_gap_cnt_nxt;
         r_stop    <= w_stop_nxt;
         r_done    <= w_done;
         if (w_acc && r_cnt != 32'hFFFF_FFFF) r_cnt <= r_cnt + 32'd1;
         if (w_load) begin
            r_gap  <= cfg_gap;
            r_mode <= cfg_mode;
         end
         if (!w_hold)
            r_data <= (w_nxt == S_SEND) ? (P_PAT | DATA_WD'(w_seq_nxt ^ w_mask)) : '0;
      end
   end

   assign enc_data = r_data;
   assign busy     = (r_state != S_IDLE);
   assign done     = r_done;
   assign tx_cnt   = r_cnt;

endmodule

// File: tb/tb_aurora_20g_enc_gen.sv
// Directed bench for aurora_20g_enc_gen: scoreboard queue of expected words, immediate-assert checks.
module tb_aurora_20g_enc_gen;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cfg_rst = 1'b0, cfg_start = 1'b0, cfg_stop = 1'b0, cfg_mode = 1'b0;
   logic [31:0] cfg_num = '0;
   logic [15:0] cfg_gap = '0;
   logic        cfg_err_inj = 1'b0;
   logic        tx_rdy = 1'b1;
   logic        enc_vld, busy, done;
   logic [63:0] enc_data;
   logic [31:0] tx_cnt;

   logic [63:0] exp_q[$];
   logic [15:0] m_seq = '0;
   int          n_vec = 0, n_err = 0, n_acc = 0;

   aurora_20g_enc_gen #(.DATA_WD(64), .GAP_WD(16)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_rst(cfg_rst), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
      .cfg_mode(cfg_mode), .cfg_num(cfg_num), .cfg_gap(cfg_gap),
`ifdef AURORA_ENC_GEN_ERR_INJ_EN
      .cfg_err_inj(cfg_err_inj),
`endif
      .tx_rdy(tx_rdy), .enc_vld(enc_vld), .enc_data(enc_data), .busy(busy), .done(done),
      .tx_cnt(tx_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] word(input logic [15:0] s);
      return {48'hBBBB_CCCC_DDDD, s};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic push_words(input int n);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(word(m_seq));
         m_seq++;
      end
   endtask

   task automatic start(input logic mode, input logic [31:0] num, input logic [15:0] gap);
      cfg_mode = mode; cfg_num = num; cfg_gap = gap; cfg_start = 1'b1;
      step();
      cfg_start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int max);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (done) begin ok = 1'b1; break; end
      end
      chk(tag, {63'd0, ok}, 64'd1);
      step();
   endtask

   // Scoreboard: every accept pops and compares the next expected word.
   always @(negedge clk) begin
      if (rst_n && !cfg_rst && enc_vld && tx_rdy) begin
         n_acc++;
         if (exp_q.size() == 0) chk("unexpected_word", enc_data, 64'hX);
         else chk("word", enc_data, exp_q.pop_front());
      end
   end

   initial begin
      logic vld_pat [7];
      int   target;
      vld_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

      // Reset state
      step(); step();
      @(negedge clk);
      chk("rst_vld", {63'd0, enc_vld}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_cnt", {32'd0, tx_cnt}, 64'd0);
      chk("rst_data", enc_data, 64'd0);
      rst_n = 1'b1;
      step();

      // Burst of 4, no backpressure
      push_words(4);
      start(1'b0, 32'd4, 16'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); chk("burst_vld", {63'd0, enc_vld}, 64'd1);
         step();
      end
      @(negedge clk);
      chk("burst_end_vld", {63'd0, enc_vld}, 64'd0);
      chk("burst_done", {63'd0, done}, 64'd1);
      chk("burst_busy", {63'd0, busy}, 64'd0);
      chk("burst_cnt", {32'd0, tx_cnt}, 64'd4);
      step();
      @(negedge clk); chk("done_pulse_1cyc", {63'd0, done}, 64'd0);
      step();

      // Backpressure on the third word of a 5-word burst
      push_words(5);
      start(1'b0, 32'd5, 16'd0);
      step(); step();
      tx_rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_vld", {63'd0, enc_vld}, 64'd1);
         chk("bp_hold", enc_data, word(16'd6));
         step();
      end
      tx_rdy = 1'b1;
      wait_done("bp_done", 20);
      chk("bp_cnt", {32'd0, tx_cnt}, 64'd9);

      // Gap of 2 between 3 words
      push_words(3);
      start(1'b0, 32'd3, 16'd2);
      for (int i = 0; i < 7; i++) begin
         @(negedge clk); chk("gap_vld", {63'd0, enc_vld}, {63'd0, vld_pat[i]});
         step();
      end
      @(negedge clk); chk("gap_done", {63'd0, done}, 64'd1);
      step();

      // Zero-length burst: stays idle, pulses done
      start(1'b0, 32'd0, 16'd0);
      @(negedge clk);
      chk("zero_done", {63'd0, done}, 64'd1);
      chk("zero_busy", {63'd0, busy}, 64'd0);
      step();

      // cfg_rst, continuous wrap through FFFF, then stop while held
      cfg_rst = 1'b1; step(); cfg_rst = 1'b0;
      m_seq = 16'd0;
      @(negedge clk); chk("crst_cnt", {32'd0, tx_cnt}, 64'd0);
      step();
      target = n_acc + 65538;
      push_words(65539);
      start(1'b1, 32'd0, 16'd0);
      for (int i = 0; i < 70000; i++) begin
         if (n_acc >= target) break;
         step();
      end
      chk("wrap_accepts", n_acc, target);
      tx_rdy = 1'b0; cfg_stop = 1'b1;
      step();
      cfg_stop = 1'b0;
      @(negedge clk);
      chk("stop_held_vld", {63'd0, enc_vld}, 64'd1);
      chk("stop_held_data", enc_data, word(16'd2));
      step();
      tx_rdy = 1'b1;
      wait_done("stop_done", 5);
      chk("wrap_cnt", {32'd0, tx_cnt}, 64'd65539);
      @(negedge clk); chk("stop_idle", {63'd0, busy}, 64'd0);
      step();

      // cfg_rst with a held word
      tx_rdy = 1'b0;
      start(1'b1, 32'd0, 16'd0);
      @(negedge clk); chk("held_before_crst", enc_data, word(m_seq));
      step();
      cfg_rst = 1'b1; step(); cfg_rst = 1'b0;
      @(negedge clk);
      chk("crst_vld", {63'd0, enc_vld}, 64'd0);
      chk("crst_busy", {63'd0, busy}, 64'd0);
      chk("crst_cnt2", {32'd0, tx_cnt}, 64'd0);
      m_seq = 16'd0;
      step();

      // rst_n with a held word, then restart from seq 0
      start(1'b0, 32'd1, 16'd0);
      rst_n = 1'b0; #1;
      chk("arst_vld", {63'd0, enc_vld}, 64'd0);
      step(); rst_n = 1'b1; tx_rdy = 1'b1;
      step();
      push_words(2);
      start(1'b0, 32'd2, 16'd0);
      wait_done("restart_done", 10);
      chk("restart_cnt", {32'd0, tx_cnt}, 64'd2);

`ifdef AURORA_ENC_GEN_ERR_INJ_EN
      cfg_rst = 1'b1; step(); cfg_rst = 1'b0;
      m_seq = 16'd0;
      for (int i = 0; i < 10; i++) begin
         exp_q.push_back(i == 7 ? {48'hBBBB_CCCC_DDDD, ~m_seq} : word(m_seq));
         m_seq++;
      end
      start(1'b0, 32'd10, 16'd0);
      for (int i = 0; i < 6; i++) step();
      cfg_err_inj = 1'b1; step(); cfg_err_inj = 1'b0;
      wait_done("inj_done", 20);
      chk("inj_cnt", {32'd0, tx_cnt}, 64'd10);
`endif

      chk("queue_empty", exp_q.size(), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/aurora_20g_enc_gen.md
Name: aurora_20g_enc_gen

Overview:
- Test-pattern source for the 20G Aurora encoder-word check path.
- Sits directly upstream of the encoder-word checker.
- Emits 64-bit words {48'hBBBB_CCCC_DDDD, seq[15:0]} with a wrapping 16-bit sequence number.
- Supports backpressure, configurable inter-word gaps, burst or continuous mode, and a transmitted-word counter.
- The checker's valid input is driven by the accept strobe (enc_vld & tx_rdy).

Parameters:
- DATA_WD, 64: output word width; must be >= 16 (low 16 bits carry seq; remaining bits carry the fixed pattern, truncated or zero-extended at the MSB end).
- GAP_WD, 16: width of the gap configuration.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- cfg_rst  input  1  synchronous clear, level; overrides everything
- cfg_start  input  1  start pulse; ignored while busy
- cfg_stop  input  1  stop request pulse
- cfg_mode  input  1  0 = burst of cfg_num words, 1 = continuous
- cfg_num  input  32  burst length in words (sampled on start)
- cfg_gap  input  GAP_WD  idle cycles inserted after each accepted word (sampled on start)
- tx_rdy  input  1  downstream ready
- enc_vld  output  1  word valid
- enc_data  output  DATA_WD  word
- busy  output  1  high in SEND or GAP
- done  output  1  one-cycle pulse when a burst or stop completes
- tx_cnt  output  32  accepted-word count, saturating

Behaviour:
- Clock/reset: one clock (clk); asynchronous active-low reset (rst_n).
- Reset / cfg_rst: state = IDLE; enc_vld = 0, enc_data = 0, busy = 0, done = 0, tx_cnt = 0, seq = 0; gap and remaining counters = 0.
- seq and tx_cnt are cleared only by rst_n/cfg_rst, never by start, so seq stays aligned with the checker across bursts.
- Accept = enc_vld & tx_rdy.
  - On accept, seq increments, wrapping 16'hFFFF -> 0.
  - On accept, tx_cnt increments, holding at 32'hFFFF_FFFF.
- Handshake: while enc_vld = 1 and tx_rdy = 0, enc_vld and enc_data hold stable. Once raised, enc_vld never drops without an accept, except on rst_n or cfg_rst.
- enc_data is registered and always equals {pattern, seq} while enc_vld = 1.
- State machine:
  - IDLE:
    - cfg_start with cfg_mode = 1, or with cfg_num != 0 → latch cfg_num/cfg_gap/cfg_mode, go to SEND.
    - enc_vld = 1 on the cycle after the start pulse (latency 1).
    - cfg_start in burst mode with cfg_num = 0 → stay IDLE and pulse done next cycle.
  - SEND: enc_vld = 1. On accept, first match wins:
    - burst mode and remaining == 1 → IDLE, done pulse.
    - stop pending → IDLE, done pulse.
    - gap != 0 → GAP.
    - otherwise stay in SEND; the next word is presented back-to-back in the following cycle.
  - GAP:
    - enc_vld = 0 for exactly cfg_gap cycles, then SEND.
    - cfg_stop in GAP → IDLE next cycle, done pulse.
- cfg_stop:
  - In SEND with a word outstanding: sets stop-pending; the held word completes, then IDLE.
  - In IDLE: no effect.
- Simultaneous cfg_start and cfg_stop in IDLE: start wins, and stop is ignored.
- cfg_start while busy: ignored.
- Register sampling: cfg_num, cfg_gap and cfg_mode changes while busy have no effect until the next start.
- busy = (state != IDLE); done and busy are registered.

Optional Feature:
- Macro: AURORA_ENC_GEN_ERR_INJ_EN.
- Defined: adds input port cfg_err_inj (1 bit, pulse), which arms a one-shot flag.
  - The next word presented has enc_data[15:0] = ~seq.
  - The flag clears on that word's accept.
  - seq still increments normally, so exactly one checker error follows.
  - The flag is cleared by cfg_rst.
- Not defined: no port; data is never corrupted.

Test Plan:
- Burst, no backpressure: cfg_mode = 0, cfg_num = 4, cfg_gap = 0, tx_rdy = 1 → enc_vld high 4 consecutive cycles starting 1 cycle after start; seq 0,1,2,3; done pulse; tx_cnt = 4; checker suc_cnt = 4, err_cnt = 0.
- Backpressure: tx_rdy low for 3 cycles while word seq = 2 is presented → enc_data stable for those 3 cycles; no seq skip or repeat; total of 5 accepts for cfg_num = 5.
- Gap: cfg_num = 3, cfg_gap = 2 → vld pattern 1,0,0,1,0,0,1, then done.
- Wrap / continuous: cfg_rst, then continuous mode for 65538 accepts → seq goes FFFF → 0 → 1; checker err_cnt = 0; cfg_stop while tx_rdy = 0 → held word accepted, then IDLE with done pulse.
- Mid-operation reset: rst_n or cfg_rst asserted in SEND with a word held → next cycle enc_vld = 0, tx_cnt = 0, seq = 0, busy = 0; restart produces seq 0.
- With AURORA_ENC_GEN_ERR_INJ_EN: pulse cfg_err_inj before the word with seq = 7 in a 10-word burst → that word has low bits 16'hFFF8; checker err_cnt = 1, suc_cnt = 9.
